tcm_banked_mem: RTL and testbench
=================================

TCM_BANKED_MEM -- requirements
Module: tcm_banked_mem

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 4, meaning word-interleaved SRAM banks; power of 2, range 1..8.
REQ-002 The block SHALL have parameter BANK_WORDS, default 1024, meaning 32-bit words per bank; power of 2.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0; aligned to total size.
REQ-004 The block SHALL have parameter MAX_IWAIT, default 2, meaning consecutive lost conflicts before the instruction port gets priority; range 1..15.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port d_req, input, 1, data-port request.
REQ-008 The block SHALL have port d_we, input, 1, data-port write (1) or read (0).
REQ-009 The block SHALL have port d_addr, input, 32, data-port byte address.
REQ-010 The block SHALL have port d_be, input, 4, data-port byte enables for writes.
REQ-011 The block SHALL have port d_wdata, input, 32, data-port write data.
REQ-012 The block SHALL have port d_gnt, output, 1, data request accepted this cycle.
REQ-013 The block SHALL have port d_rvalid, output, 1, data response valid.
REQ-014 The block SHALL have port d_rdata, output, 32, data read data.
REQ-015 The block SHALL have port d_err, output, 1, data response error; qualified by d_rvalid.
REQ-016 The block SHALL have port i_req, input, 1, instruction-fetch request, read only.
REQ-017 The block SHALL have port i_addr, input, 32, fetch byte address.
REQ-018 The block SHALL have ports i_gnt, i_rvalid, i_rdata[31:0] and i_err, outputs, with the same meanings as the data-port equivalents.

Function
REQ-019 Bank select SHALL be addr[2+log2(NUM_BANKS)-1:2]; the in-bank index SHALL be the next log2(BANK_WORDS) bits above the bank select, taken after BASE_ADDR is subtracted.
REQ-020 A request granted in cycle N SHALL produce rvalid in cycle N+1, exactly once; reads return the addressed word.
REQ-021 Rdata/err SHALL hold their last value while rvalid=0.
REQ-022 Granted writes SHALL update only the bytes whose d_be bit is 1; the response SHALL be d_rvalid=1, d_err=0, d_rdata=0.
REQ-023 When the two ports address different banks, both SHALL be granted in the same cycle.
REQ-024 When the two ports address the same bank, one SHALL be granted and the other SHALL see gnt=0.
REQ-025 In a same-bank conflict the data port SHALL win, unless iwait_cnt==MAX_IWAIT, in which case the instruction port SHALL win.
REQ-026 iwait_cnt SHALL increment when the instruction port loses a conflict, saturate at MAX_IWAIT, and clear whenever i_gnt=1.
REQ-027 The requester SHALL hold req/addr/data stable until gnt; a request withdrawn before gnt SHALL be discarded without effect.
REQ-028 An address outside [BASE_ADDR, BASE_ADDR+4*NUM_BANKS*BANK_WORDS) SHALL be granted immediately, with no bank access, and answered with rvalid=1, err=1, rdata=0.
REQ-029 An address with addr[1:0]!=0 SHALL be handled like REQ-028.
REQ-030 Error requests SHALL not take part in conflict arbitration.
REQ-031 A write with d_be=0 SHALL be granted and acknowledged with no memory change.
REQ-032 A read issued the cycle after a granted write to the same word SHALL return the newly written data.

Reset
REQ-033 While rst_n=0, all gnt, rvalid and err outputs SHALL be 0, rdata outputs 0 and iwait_cnt 0; bank contents SHALL NOT be reset.
REQ-034 A reset asserted mid-transaction SHALL drop any pending response; after release the first cycle SHALL accept new requests normally.
REQ-035 Grants SHALL be combinational from req/addr and the registered iwait_cnt, and SHALL be forced to 0 while rst_n=0.

Structure
REQ-036 Package tcm_pkg SHALL hold the default parameter constants, the bank-select and in-range helper functions, and the response struct (rvalid, err, rdata).
REQ-037 Sub-module tcm_bank SHALL be a single-port, synchronous-read, byte-write RAM of BANK_WORDS x 32, instantiated NUM_BANKS times via generate.
REQ-038 Arbitration, range checking and response registers SHALL live in tcm_banked_mem.

Verification
REQ-039 Scenario: d write 0x0000_0010 be=4'b0101 wdata=0xAABBCCDD over 0x11223344, then d read -> rdata=0x11BB33DD one cycle after gnt.
REQ-040 Scenario: d read 0x0000_0000 and i read 0x0000_0004 in the same cycle -> both gnt=1, both rvalid in the next cycle.
REQ-041 Scenario: d and i both requesting bank 0 for 4 cycles, MAX_IWAIT=2 -> i_gnt pattern 0,0,1,0, d_gnt its complement.
REQ-042 Scenario: i_addr=0x0000_4000 with default size (16 KiB) -> i_gnt=1, then i_rvalid=1, i_err=1, i_rdata=0; d_addr=0x0000_0002 -> d_err=1.
REQ-043 Scenario: write 0xDEADBEEF to 0x20, then read 0x20 the next cycle -> 0xDEADBEEF.
REQ-044 Scenario: assert rst_n=0 in the cycle after a read grant -> no rvalid; after release a new read completes with 1-cycle latency.

Source files
------------

// File: rtl/tcm_pkg.sv
// Shared constants, address helpers and the response record for the banked TCM.
// Helpers assume BASE_ADDR is aligned to the total memory size.
package tcm_pkg;

   localparam int unsigned NUM_BANKS_DEF  = 4;
   localparam int unsigned BANK_WORDS_DEF = 1024;
   localparam logic [31:0] BASE_ADDR_DEF  = 32'h0000_0000;
   localparam int unsigned MAX_IWAIT_DEF  = 2;

   typedef struct packed {
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } tcm_rsp_t;

   function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

   function automatic logic [31:0] bank_sel(input logic [31:0] addr, input logic [31:0] base,
                                            input int unsigned bsel_bits);
      return word_off(addr, base) & ((32'd1 << bsel_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] bank_index(input logic [31:0] addr, input logic [31:0] base,
                                              input int unsigned bsel_bits);
      return word_off(addr, base) >> bsel_bits;
   endfunction

   // 33-bit offset so a region ending exactly at 4 GiB still compares correctly
   function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [32:0] size_bytes);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, base};
      return (addr >= base) && (off < size_bytes);
   endfunction

   function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [32:0] size_bytes);
      return in_range(addr, base, size_bytes) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/tcm_bank.sv
// One word-wide SRAM bank: single port, synchronous read, per-byte write enables.
// Contents and read register are deliberately not reset.
module tcm_bank #(
   parameter  int unsigned WORDS = 1024,
   localparam int unsigned AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/tcm_banked_mem.sv
// Two-port (data + fetch) tightly-coupled memory built from word-interleaved banks.
// Same-bank conflicts favour the data port until the fetch port has lost MAX_IWAIT times in a row.
module tcm_banked_mem
   import tcm_pkg::*;
#(
   parameter int unsigned NUM_BANKS  = NUM_BANKS_DEF,
   parameter int unsigned BANK_WORDS = BANK_WORDS_DEF,
   parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
   parameter int unsigned MAX_IWAIT  = MAX_IWAIT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err
);

   localparam int unsigned BSEL_BITS  = $clog2(NUM_BANKS);
   localparam int unsigned BSEL_W     = (BSEL_BITS == 0) ? 1 : BSEL_BITS;
   localparam int unsigned IDX_W      = $clog2(BANK_WORDS);
   localparam int unsigned IW_W       = 4;
   localparam logic [32:0] SIZE_BYTES = (33'(NUM_BANKS) * 33'(BANK_WORDS)) << 2;

   logic              d_ok, i_ok, conflict, i_prio;
   logic [BSEL_W-1:0] d_bank, i_bank;
   logic [IDX_W-1:0]  d_idx, i_idx;
   logic [IW_W-1:0]   iwait_q, iwait_d;
   logic [31:0]       bank_rdata [2**BSEL_W];

   always_comb begin
      d_ok     = addr_ok(d_addr, BASE_ADDR, SIZE_BYTES);
      i_ok     = addr_ok(i_addr, BASE_ADDR, SIZE_BYTES);
      d_bank   = BSEL_W'(bank_sel(d_addr, BASE_ADDR, BSEL_BITS));
      i_bank   = BSEL_W'(bank_sel(i_addr, BASE_ADDR, BSEL_BITS));
      d_idx    = IDX_W'(bank_index(d_addr, BASE_ADDR, BSEL_BITS));
      i_idx    = IDX_W'(bank_index(i_addr, BASE_ADDR, BSEL_BITS));
      // error requests never touch a bank, so they never contend
      conflict = d_req && d_ok && i_req && i_ok && (d_bank == i_bank);
      i_prio   = (iwait_q == IW_W'(MAX_IWAIT));
      d_gnt    = rst_n && d_req && !(conflict && i_prio);
      i_gnt    = rst_n && i_req && !(conflict && !i_prio);
   end

   always_comb begin
      iwait_d = iwait_q;
      if (i_gnt)                                         iwait_d = '0;
      else if (conflict && (iwait_q < IW_W'(MAX_IWAIT))) iwait_d = iwait_q + 1'b1;
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic d_sel, i_sel;
      assign d_sel = d_gnt && d_ok && (d_bank == BSEL_W'(b));
      assign i_sel = i_gnt && i_ok && (i_bank == BSEL_W'(b));

      tcm_bank #(.WORDS(BANK_WORDS)) u_bank (
         .clk   (clk),
         .en    (d_sel || i_sel),
         .we    (d_sel && d_we),
         .be    (d_be),
         .addr  (d_sel ? d_idx : i_idx),
         .wdata (d_wdata),
         .rdata (bank_rdata[b])
      );
   end

   for (genvar b = NUM_BANKS; b < 2**BSEL_W; b++) begin : g_pad
      assign bank_rdata[b] = '0;
   end

   logic              d_rvalid_q, d_err_q, d_rd_q;
   logic              i_rvalid_q, i_err_q, i_rd_q;
   logic [BSEL_W-1:0] d_bank_q, i_bank_q;
   logic [31:0]       d_rdata_q, i_rdata_q;
   tcm_rsp_t          d_rsp, i_rsp;

   // rdata is live from the bank in the response cycle and held in a register afterwards
   always_comb begin
      d_rsp.rvalid = d_rvalid_q;
      d_rsp.err    = d_err_q;
      d_rsp.rdata  = d_rvalid_q ? (d_rd_q ? bank_rdata[d_bank_q] : 32'h0) : d_rdata_q;
      i_rsp.rvalid = i_rvalid_q;
      i_rsp.err    = i_err_q;
      i_rsp.rdata  = i_rvalid_q ? (i_rd_q ? bank_rdata[i_bank_q] : 32'h0) : i_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iwait_q    <= '0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         d_rd_q     <= 1'b0;
         d_bank_q   <= '0;
         d_rdata_q  <= '0;
         i_rvalid_q <= 1'b0;
         i_err_q    <= 1'b0;
         i_rd_q     <= 1'b0;
         i_bank_q   <= '0;
         i_rdata_q  <= '0;
      end else begin
         iwait_q    <= iwait_d;
         d_rvalid_q <= d_gnt;
         i_rvalid_q <= i_gnt;
         if (d_gnt) begin
            d_err_q  <= !d_ok;
            d_rd_q   <= d_ok && !d_we;
            d_bank_q <= d_bank;
         end
         if (i_gnt) begin
            i_err_q  <= !i_ok;
            i_rd_q   <= i_ok;
            i_bank_q <= i_bank;
         end
         if (d_rvalid_q) d_rdata_q <= d_rsp.rdata;
         if (i_rvalid_q) i_rdata_q <= i_rsp.rdata;
      end
   end

   assign d_rvalid = d_rsp.rvalid;
   assign d_err    = d_rsp.err;
   assign d_rdata  = d_rsp.rdata;
   assign i_rvalid = i_rsp.rvalid;
   assign i_err    = i_rsp.err;
   assign i_rdata  = i_rsp.rdata;

endmodule

// File: tb/tb_tcm_banked_mem.sv
// Directed bench for tcm_banked_mem with a word-array reference model checked every cycle.
module tb_tcm_banked_mem;

   localparam int unsigned NB    = 4;
   localparam int unsigned SIZE  = 16384;
   localparam int unsigned MAXW  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        d_req, d_we, i_req;
   logic [31:0] d_addr, d_wdata, i_addr;
   logic [3:0]  d_be;
   logic        d_gnt, d_rvalid, d_err, i_gnt, i_rvalid, i_err;
   logic [31:0] d_rdata, i_rdata;

   int errors = 0;
   int checks = 0;

   tcm_banked_mem dut (
      .clk(clk), .rst_n(rst_n),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .i_req(i_req), .i_addr(i_addr),
      .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_mem   [4096];
   bit          m_known [4096];
   int unsigned m_iw;
   bit          dp_v, dp_e, dp_k, ip_v, ip_e, ip_k;
   logic [31:0] dp_d, ip_d;
   bit          dh_e, dh_k, ih_e, ih_k;
   logic [31:0] dh_d, ih_d;

   function automatic bit m_ok(input logic [31:0] a);
      return (a < SIZE) && (a % 4 == 0);
   endfunction

   function automatic int unsigned m_bank(input logic [31:0] a);
      return (a / 4) % NB;
   endfunction

   always @(negedge clk) begin : cmp
      bit dv, iv, clash, ifirst, eg_d, eg_i;
      int unsigned w;
      if (!rst_n) begin
         chk("rst d_gnt", d_gnt, 0);       chk("rst i_gnt", i_gnt, 0);
         chk("rst d_rvalid", d_rvalid, 0); chk("rst i_rvalid", i_rvalid, 0);
         chk("rst d_err", d_err, 0);       chk("rst i_err", i_err, 0);
         chk("rst d_rdata", d_rdata, 0);   chk("rst i_rdata", i_rdata, 0);
         dp_v = 0; ip_v = 0; m_iw = 0;
         dh_d = 0; dh_e = 0; dh_k = 1; ih_d = 0; ih_e = 0; ih_k = 1;
      end else begin
         chk("m d_rvalid", d_rvalid, dp_v);
         chk("m i_rvalid", i_rvalid, ip_v);
         if (dp_v) begin dh_d = dp_d; dh_e = dp_e; dh_k = dp_k; end
         if (ip_v) begin ih_d = ip_d; ih_e = ip_e; ih_k = ip_k; end
         chk("m d_err", d_err, dh_e);
         chk("m i_err", i_err, ih_e);
         if (dh_k) chk("m d_rdata", d_rdata, dh_d);
         if (ih_k) chk("m i_rdata", i_rdata, ih_d);

         dv     = d_req && m_ok(d_addr);
         iv     = i_req && m_ok(i_addr);
         clash  = dv && iv && (m_bank(d_addr) == m_bank(i_addr));
         ifirst = (m_iw == MAXW);
         eg_d   = d_req && !(clash && ifirst);
         eg_i   = i_req && !(clash && !ifirst);
         chk("m d_gnt", d_gnt, eg_d);
         chk("m i_gnt", i_gnt, eg_i);

         ip_v = eg_i;
         if (eg_i) begin
            ip_e = !iv;
            w    = i_addr / 4;
            ip_d = iv ? m_mem[w % 4096] : 32'h0;
            ip_k = iv ? m_known[w % 4096] : 1'b1;
         end
         dp_v = eg_d;
         if (eg_d) begin
            dp_e = !dv;
            w    = d_addr / 4;
            dp_d = 32'h0; dp_k = 1'b1;
            if (dv && !d_we) begin dp_d = m_mem[w % 4096]; dp_k = m_known[w % 4096]; end
            if (dv && d_we) begin
               for (int b = 0; b < 4; b++)
                  if (d_be[b]) m_mem[w % 4096][8*b +: 8] = d_wdata[8*b +: 8];
               if (d_be == 4'hF) m_known[w % 4096] = 1'b1;
            end
         end
         if (eg_i)       m_iw = 0;
         else if (clash) m_iw = (m_iw + 1 > MAXW) ? MAXW : m_iw + 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic next_cyc();
      @(posedge clk); #1;
   endtask

   task automatic d_access(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
      int n = 0;
      d_req = 1; d_we = we; d_addr = a; d_be = be; d_wdata = wd;
      @(negedge clk);
      while (!d_gnt && n < 50) begin n++; @(negedge clk); end
      chk("d_gnt timeout", d_gnt, 1);
      next_cyc();
      d_req = 0; d_we = 0;
   endtask

   typedef struct {
      logic dr; logic dw; logic [31:0] da; logic [3:0] be; logic [31:0] dd;
      logic ir; logic [31:0] ia;
   } vec_t;

   vec_t vecs [9] = '{
      '{1, 1, 32'h24, 4'hF, 32'h0123_4567, 1, 32'h28},
      '{1, 0, 32'h24, 4'h0, 32'h0,         1, 32'h34},
      '{1, 1, 32'h30, 4'hC, 32'hFFFF_0000, 1, 32'h30},
      '{1, 0, 32'h30, 4'h0, 32'h0,         1, 32'h3C},
      '{0, 0, 32'h0,  4'h0, 32'h0,         1, 32'h24},
      '{1, 1, 32'h50, 4'hF, 32'h55AA_55AA, 1, 32'h8000},
      '{1, 0, 32'h50, 4'h0, 32'h0,         1, 32'h00},
      '{1, 0, 32'h50, 4'h0, 32'h0,         1, 32'h00},
      '{0, 0, 32'h0,  4'h0, 32'h0,         0, 32'h0}
   };

   logic [3:0] exp_ig;

   initial begin
      d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0; i_req = 0; i_addr = 0;
      rst_n = 1;
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      for (int k = 0; k < 16; k++) d_access(1, 32'(k * 4), 4'hF, 32'hC0DE_0000 | 32'(k));

      d_access(1, 32'h10, 4'hF, 32'h1122_3344);
      d_access(1, 32'h10, 4'b0101, 32'hAABB_CCDD);
      d_access(0, 32'h10, 4'h0, 32'h0);
      @(negedge clk);
      chk("be merge rvalid", d_rvalid, 1);
      chk("be merge rdata", d_rdata, 32'h11BB_33DD);
      next_cyc();

      d_access(1, 32'h20, 4'hF, 32'hDEAD_BEEF);
      d_access(0, 32'h20, 4'h0, 32'h0);
      @(negedge clk);
      chk("raw rdata", d_rdata, 32'hDEAD_BEEF);
      next_cyc();

      d_access(1, 32'h20, 4'h0, 32'h0);
      d_access(0, 32'h20, 4'h0, 32'h0);
      @(negedge clk);
      chk("be0 rdata", d_rdata, 32'hDEAD_BEEF);
      next_cyc();

      d_req = 1; d_addr = 32'h0; i_req = 1; i_addr = 32'h4;
      @(negedge clk);
      chk("dual d_gnt", d_gnt, 1);
      chk("dual i_gnt", i_gnt, 1);
      next_cyc();
      d_req = 0; i_req = 0;
      @(negedge clk);
      chk("dual d_rvalid", d_rvalid, 1);
      chk("dual i_rvalid", i_rvalid, 1);
      chk("dual d_rdata", d_rdata, 32'hC0DE_0000);
      chk("dual i_rdata", i_rdata, 32'hC0DE_0001);
      next_cyc();

      exp_ig = 4'b0100;
      d_req = 1; d_addr = 32'h0; i_req = 1; i_addr = 32'h10;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("conflict i_gnt[%0d]", k), i_gnt, exp_ig[k]);
         chk($sformatf("conflict d_gnt[%0d]", k), d_gnt, !exp_ig[k]);
         next_cyc();
      end
      d_req = 0; i_req = 0;
      next_cyc();

      d_req = 1; d_addr = 32'h4000; i_req = 1; i_addr = 32'h0;
      @(negedge clk);
      chk("errnoarb d_gnt", d_gnt, 1);
      chk("errnoarb i_gnt", i_gnt, 1);
      next_cyc();
      d_addr = 32'h2; i_addr = 32'h4000;
      @(negedge clk);
      chk("errnoarb d_err", d_err, 1);
      chk("errnoarb i_err", i_err, 0);
      chk("oob i_gnt", i_gnt, 1);
      chk("misalign d_gnt", d_gnt, 1);
      next_cyc();
      d_req = 0; i_req = 0;
      @(negedge clk);
      chk("oob i_rvalid", i_rvalid, 1);
      chk("oob i_err", i_err, 1);
      chk("oob i_rdata", i_rdata, 0);
      chk("misalign d_err", d_err, 1);
      chk("misalign d_rdata", d_rdata, 0);
      next_cyc();

      foreach (vecs[k]) begin
         d_req = vecs[k].dr; d_we = vecs[k].dw; d_addr = vecs[k].da; d_be = vecs[k].be;
         d_wdata = vecs[k].dd; i_req = vecs[k].ir; i_addr = vecs[k].ia;
         next_cyc();
      end
      d_req = 0; d_we = 0; i_req = 0;
      next_cyc();

      d_req = 1; d_we = 0; d_addr = 32'h20;
      @(negedge clk);
      chk("prereset d_gnt", d_gnt, 1);
      next_cyc();
      d_req = 0; rst_n = 0;
      @(negedge clk);
      chk("dropped d_rvalid", d_rvalid, 0);
      next_cyc();
      next_cyc();
      rst_n = 1; d_req = 1; d_addr = 32'h10;
      @(negedge clk);
      chk("postreset d_gnt", d_gnt, 1);
      next_cyc();
      d_req = 0;
      @(negedge clk);
      chk("postreset d_rvalid", d_rvalid, 1);
      chk("postreset d_rdata", d_rdata, 32'h11BB_33DD);
      next_cyc();
      repeat (3) next_cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
